// File: rtl/fan_pkg.sv
// Shared types and constants for the fan mode controller: state, speed and
// off-timer codes, preset multipliers and the remaining-seconds width.
package fan_pkg;

    localparam int unsigned REMAIN_W = 18;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SPD_OFF = 2'd0,
        SPD_1   = 2'd1,
        SPD_2   = 2'd2,
        SPD_3   = 2'd3
    } speed_t;

    typedef enum logic [1:0] {
        TMR_NONE = 2'd0,
        TMR_1    = 2'd1,
        TMR_3    = 2'd2,
        TMR_5    = 2'd3
    } timer_sel_t;

    localparam int unsigned PRESET_MULT_1 = 1;
    localparam int unsigned PRESET_MULT_3 = 3;
    localparam int unsigned PRESET_MULT_5 = 5;

    function automatic int unsigned preset_mult(input timer_sel_t sel);
        case (sel)
            TMR_1:   return PRESET_MULT_1;
            TMR_3:   return PRESET_MULT_3;
            TMR_5:   return PRESET_MULT_5;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/fan_sec_tick.sv
// Seconds prescaler: counts 0..CLK_PER_SEC-1 while enabled and flags the wrap
// cycle on tick. Synchronous clear restarts the full second.
module fan_sec_tick #(
    parameter int unsigned CLK_PER_SEC = 125_000_000
) (
    input  logic clk,
    input  logic reset_p,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset_p || clr || !en) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Kept independent of clr so the controller's clear decision cannot loop back.
    assign tick = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/fan_mode_ctrl.sv
// Fan mode controller: gesture pulses drive speed, off-timer preset and power.
// Optional soft-start duty ramp is built when FAN_SOFT_START_EN is defined.
module fan_mode_ctrl
    import fan_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC    = 125_000_000,
    parameter int unsigned TIMER_UNIT_SEC = 3600,
    parameter int unsigned DUTY_L1        = 85,
    parameter int unsigned DUTY_L2        = 170,
    parameter int unsigned DUTY_L3        = 255,
    parameter int unsigned RAMP_CYCLES    = 125_000
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic                single_i,
    input  logic                double_i,
    input  logic                long_i,
    output logic [1:0]          speed,
    output logic [1:0]          timer_sel,
    output logic [REMAIN_W-1:0] remain_sec,
    output logic [7:0]          duty,
    output logic                running,
    output logic                expired
);

    if (5 * TIMER_UNIT_SEC > (2 ** REMAIN_W) - 1) begin : g_width_check
        $error("5*TIMER_UNIT_SEC does not fit in remain_sec");
    end
    if (CLK_PER_SEC == 0 || RAMP_CYCLES == 0) begin : g_zero_check
        $error("CLK_PER_SEC and RAMP_CYCLES must be nonzero");
    end

    state_t                state_q, state_n;
    speed_t                speed_q, speed_n;
    timer_sel_t            tsel_q, tsel_n;
    logic [REMAIN_W-1:0]   remain_q, remain_n;
    logic [7:0]            duty_q, duty_n, target_n;
    logic                  expired_q, expired_n;
    logic                  tick, tick_en, tick_clr;

    function automatic logic [7:0] duty_for(input speed_t s);
        case (s)
            SPD_1:   return 8'(DUTY_L1);
            SPD_2:   return 8'(DUTY_L2);
            SPD_3:   return 8'(DUTY_L3);
            default: return 8'd0;
        endcase
    endfunction

    assign tick_en = (state_q == ST_RUN) && (tsel_q != TMR_NONE);

    fan_sec_tick #(
        .CLK_PER_SEC(CLK_PER_SEC)
    ) u_sec_tick (
        .clk    (clk),
        .reset_p(reset_p),
        .en     (tick_en),
        .clr    (tick_clr),
        .tick   (tick)
    );

    // Priority: long = expiry > double > single; lower events are dropped.
    always_comb begin
        state_n   = state_q;
        speed_n   = speed_q;
        tsel_n    = tsel_q;
        remain_n  = remain_q;
        expired_n = 1'b0;
        tick_clr  = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (single_i) begin
                    state_n  = ST_RUN;
                    speed_n  = SPD_1;
                    tsel_n   = TMR_NONE;
                    remain_n = '0;
                end
            end
            ST_RUN: begin
                if (long_i || (tick && remain_q == REMAIN_W'(1))) begin
                    state_n   = ST_OFF;
                    speed_n   = SPD_OFF;
                    tsel_n    = TMR_NONE;
                    remain_n  = '0;
                    expired_n = !long_i;
                end else if (double_i) begin
                    tsel_n   = timer_sel_t'(tsel_q + 2'd1);
                    remain_n = REMAIN_W'(preset_mult(tsel_n) * TIMER_UNIT_SEC);
                    tick_clr = 1'b1;
                end else begin
                    if (single_i) begin
                        speed_n = (speed_q == SPD_3) ? SPD_1 : speed_t'(speed_q + 2'd1);
                    end
                    if (tick) begin
                        remain_n = remain_q - REMAIN_W'(1);
                    end
                end
            end
            default: state_n = ST_OFF;
        endcase
        target_n = duty_for(speed_n);
    end

`ifdef FAN_SOFT_START_EN
    localparam int unsigned RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [RAMP_W-1:0] RAMP_MAX = RAMP_W'(RAMP_CYCLES - 1);

    logic [RAMP_W-1:0] ramp_q, ramp_n;
    logic [7:0]        target_cur;

    assign target_cur = duty_for(speed_q);

    // Drops follow the next-state target at once; rises follow the settled
    // speed so a ramp step never lands on the edge that powers off.
    always_comb begin
        duty_n = duty_q;
        ramp_n = '0;
        if (target_n < duty_q) begin
            duty_n = target_n;
        end else if (duty_q < target_cur && duty_q < target_n) begin
            if (ramp_q == RAMP_MAX) begin
                duty_n = duty_q + 8'd1;
            end else begin
                ramp_n = ramp_q + RAMP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_n;
        end
    end
`else
    assign duty_n = target_n;
`endif

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q   <= ST_OFF;
            speed_q   <= SPD_OFF;
            tsel_q    <= TMR_NONE;
            remain_q  <= '0;
            duty_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            speed_q   <= speed_n;
            tsel_q    <= tsel_n;
            remain_q  <= remain_n;
            duty_q    <= duty_n;
            expired_q <= expired_n;
        end
    end

    assign speed      = speed_q;
    assign timer_sel  = tsel_q;
    assign remain_sec = remain_q;
    assign duty       = duty_q;
    assign running    = (state_q == ST_RUN);
    assign expired    = expired_q;

endmodule

// File: tb/tb_fan_mode_ctrl.sv
// Directed bench for fan_mode_ctrl with CLK_PER_SEC=10, TIMER_UNIT_SEC=2, RAMP_CYCLES=4.
module tb_fan_mode_ctrl;

    logic        clk = 1'b0;
    logic        reset_p, single_i, double_i, long_i;
    logic [1:0]  speed, timer_sel;
    logic [17:0] remain_sec;
    logic [7:0]  duty;
    logic        running, expired;

    int checks = 0;
    int errors = 0;

    // {speed, timer_sel, remain_sec, running, expired}
    logic [23:0] st;
    logic [23:0] exp_st;
    assign st = {speed, timer_sel, remain_sec, running, expired};

    fan_mode_ctrl #(
        .CLK_PER_SEC   (10),
        .TIMER_UNIT_SEC(2),
        .DUTY_L1       (85),
        .DUTY_L2       (170),
        .DUTY_L3       (255),
        .RAMP_CYCLES   (4)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .single_i  (single_i),
        .double_i  (double_i),
        .long_i    (long_i),
        .speed     (speed),
        .timer_sel (timer_sel),
        .remain_sec(remain_sec),
        .duty      (duty),
        .running   (running),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic d, input logic l);
        single_i = s;
        double_i = d;
        long_i   = l;
        @(negedge clk);
        single_i = 1'b0;
        double_i = 1'b0;
        long_i   = 1'b0;
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        wait_cycles(2);
        reset_p = 1'b0;
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        wait_cycles(2);
        exp_st = 24'd0;
        checks++;
        if (st !== exp_st || duty !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got st=%h duty=%0d, want st=%h duty=0", st, duty, exp_st);
        end
        reset_p = 1'b0;
        wait_cycles(3);
        checks++;
        if (st !== exp_st || duty !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle: got st=%h duty=%0d, want st=%h duty=0", st, duty, exp_st);
        end
    endtask

    task automatic test_speed();
        int spd[3] = '{2, 3, 1};
        int dty[3] = '{170, 255, 85};
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        exp_st = {2'd1, 2'd0, 18'd0, 1'b1, 1'b0};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL speed_on: got st=%h, want st=%h", st, exp_st);
        end
`ifndef FAN_SOFT_START_EN
        checks++;
        if (duty !== 8'd85) begin
            errors++;
            $display("FAIL duty_on: got %0d, want 85", duty);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            exp_st = {2'(spd[i]), 2'd0, 18'd0, 1'b1, 1'b0};
            checks++;
            if (st !== exp_st) begin
                errors++;
                $display("FAIL speed_step%0d: got st=%h, want st=%h", i, st, exp_st);
            end
`ifndef FAN_SOFT_START_EN
            checks++;
            if (duty !== 8'(dty[i])) begin
                errors++;
                $display("FAIL duty_step%0d: got %0d, want %0d", i, duty, dty[i]);
            end
`endif
        end
    endtask

    task automatic test_countdown();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        exp_st = {2'd1, 2'd1, 18'd2, 1'b1, 1'b0};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL cd_load: got st=%h, want st=%h", st, exp_st);
        end
        wait_cycles(9);
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL cd_before_tick: got st=%h, want st=%h", st, exp_st);
        end
        wait_cycles(1);
        exp_st = {2'd1, 2'd1, 18'd1, 1'b1, 1'b0};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL cd_first_tick: got st=%h, want st=%h", st, exp_st);
        end
        wait_cycles(9);
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL cd_before_expiry: got st=%h, want st=%h", st, exp_st);
        end
        wait_cycles(1);
        exp_st = {2'd0, 2'd0, 18'd0, 1'b0, 1'b1};
        checks++;
        if (st !== exp_st || duty !== 8'd0) begin
            errors++;
            $display("FAIL cd_expiry: got st=%h duty=%0d, want st=%h duty=0", st, duty, exp_st);
        end
        wait_cycles(1);
        exp_st = 24'd0;
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL cd_expired_one_cycle: got st=%h, want st=%h", st, exp_st);
        end
    endtask

    task automatic test_presets();
        int tsl[4] = '{1, 2, 3, 0};
        int rem[4] = '{2, 6, 10, 0};
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            exp_st = {2'd1, 2'(tsl[i]), 18'(rem[i]), 1'b1, 1'b0};
            checks++;
            if (st !== exp_st) begin
                errors++;
                $display("FAIL preset%0d: got st=%h, want st=%h", i, st, exp_st);
            end
        end
        wait_cycles(100);
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL no_timer_hold: got st=%h, want st=%h", st, exp_st);
        end
        pulse(1'b0, 1'b1, 1'b0);
        wait_cycles(5);
        pulse(1'b0, 1'b1, 1'b0);
        wait_cycles(9);
        exp_st = {2'd1, 2'd2, 18'd6, 1'b1, 1'b0};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL restart_hold: got st=%h, want st=%h", st, exp_st);
        end
        wait_cycles(1);
        exp_st = {2'd1, 2'd2, 18'd5, 1'b1, 1'b0};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL restart_tick: got st=%h, want st=%h", st, exp_st);
        end
    endtask

    task automatic test_priority();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        exp_st = 24'd0;
        checks++;
        if (st !== exp_st || duty !== 8'd0) begin
            errors++;
            $display("FAIL long_over_single: got st=%h duty=%0d, want st=%h duty=0", st, duty, exp_st);
        end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (st !== exp_st || duty !== 8'd0) begin
            errors++;
            $display("FAIL off_double: got st=%h duty=%0d, want st=%h duty=0", st, duty, exp_st);
        end
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (st !== exp_st || duty !== 8'd0) begin
            errors++;
            $display("FAIL off_long: got st=%h duty=%0d, want st=%h duty=0", st, duty, exp_st);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        exp_st = {2'd1, 2'd1, 18'd2, 1'b1, 1'b0};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL double_over_single: got st=%h, want st=%h", st, exp_st);
        end
    endtask

    task automatic test_expiry_collision();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_cycles(19);
        pulse(1'b1, 1'b0, 1'b0);
        exp_st = {2'd0, 2'd0, 18'd0, 1'b0, 1'b1};
        checks++;
        if (st !== exp_st || duty !== 8'd0) begin
            errors++;
            $display("FAIL expiry_over_single: got st=%h duty=%0d, want st=%h duty=0", st, duty, exp_st);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_cycles(5);
        reset_p = 1'b1;
        @(negedge clk);
        exp_st = 24'd0;
        checks++;
        if (st !== exp_st || duty !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_countdown: got st=%h duty=%0d, want st=%h duty=0", st, duty, exp_st);
        end
        reset_p = 1'b0;
        wait_cycles(12);
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL after_reset_quiet: got st=%h, want st=%h", st, exp_st);
        end
    endtask

`ifdef FAN_SOFT_START_EN
    task automatic test_soft_start();
        int pts[5] = '{3, 4, 339, 340, 348};
        int dty[5] = '{0, 1, 84, 85, 85};
        int t = 0;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_cycles(pts[i] - t);
            t = pts[i];
            checks++;
            if (duty !== 8'(dty[i])) begin
                errors++;
                $display("FAIL ramp_at_%0d: got %0d, want %0d", pts[i], duty, dty[i]);
            end
        end
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (duty !== 8'd0 || st !== 24'd0) begin
            errors++;
            $display("FAIL ramp_off_drop: got duty=%0d st=%h, want duty=0 st=0", duty, st);
        end
    endtask
`endif

    initial begin
        reset_p  = 1'b1;
        single_i = 1'b0;
        double_i = 1'b0;
        long_i   = 1'b0;
        @(negedge clk);
        test_reset();
        test_speed();
        test_countdown();
        test_presets();
        test_priority();
        test_expiry_collision();
`ifdef FAN_SOFT_START_EN
        test_soft_start();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
